// File: rtl/cam_rx_if.sv
// Parallel camera receiver: frames/lines the byte stream, pairs RGB565 bytes
// and queues tagged pixels for a valid/ready consumer.
module cam_rx_if #(
  parameter int HRES       = 640,
  parameter int VRES       = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        cam_vsync_i,
  input  logic        cam_href_i,
  input  logic [7:0]  cam_data_i,
  output logic [15:0] pix_data_o,
  output logic        pix_sof_o,
  output logic        pix_eol_o,
  output logic        pix_eof_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic [15:0] frame_cnt_o,
  output logic        line_err_o,
  output logic        frame_err_o,
  output logic        ovf_o,
  input  logic        clr_err_i
);

  localparam int CW = $clog2(HRES + 1);
  localparam int LW = $clog2(VRES + 1);
  localparam int BW = $clog2(2 * HRES + 2);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] COL_LAST = CW'(HRES - 1);
  localparam logic [CW-1:0] COL_END  = CW'(HRES);
  localparam logic [LW-1:0] LN_LAST  = LW'(VRES - 1);
  localparam logic [LW-1:0] LN_END   = LW'(VRES);
  localparam logic [BW-1:0] B_LINE   = BW'(2 * HRES);
  localparam logic [BW-1:0] B_MAX    = BW'(2 * HRES + 1);
  localparam logic [AW:0]   F_FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    WAIT_LINE,
    LINE
  } state_t;

  state_t        state;
  logic          vs1, vs2, hr1, hr2;
  logic [7:0]    d1;
  logic          phase;
  logic [7:0]    hi;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [BW-1:0] bcnt;
  logic          sof_arm;
  logic          lerr_frm;

  logic [18:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0]   cnt;

  logic vs_rise, hr_rise, hr_fall;
  logic in_frame, frame_end, byte_ok, line_end;
  logic push_req, push, pop, full;
  logic eol, eof;
  logic lerr_set, ferr_set, ovf_set;
  logic [18:0] head;

  assign vs_rise   = vs1 & ~vs2;
  assign hr_rise   = hr1 & ~hr2;
  assign hr_fall   = ~hr1 & hr2;
  assign in_frame  = (state == WAIT_LINE) | (state == LINE);
  assign frame_end = en_i & in_frame & vs_rise;
  assign byte_ok   = en_i & ~vs_rise &
                     (((state == LINE) & hr1) |
                      ((state == WAIT_LINE) & hr_rise));
  assign line_end  = en_i & ~vs_rise & (state == LINE) & hr_fall;

  // Pixels past the end of the line are never queued.
  assign push_req  = byte_ok & phase & (col < COL_END);
  assign eol       = (col == COL_LAST);
  assign eof       = eol & (line == LN_LAST);

  assign lerr_set  = line_end & (bcnt != B_LINE);
  assign ferr_set  = frame_end & ((line != LN_END) | hr1);

  assign full      = (cnt == F_FULL);
  assign pix_valid_o = (cnt != '0);
  assign pop       = pix_valid_o & pix_ready_i;
  assign push      = push_req & (~full | pop);
  assign ovf_set   = push_req & full & ~pop;

  assign head        = mem[rd];
  assign pix_sof_o   = pix_valid_o & head[18];
  assign pix_eol_o   = pix_valid_o & head[17];
  assign pix_eof_o   = pix_valid_o & head[16];
  assign pix_data_o  = pix_valid_o ? head[15:0] : 16'h0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vs1         <= 1'b0;
      vs2         <= 1'b0;
      hr1         <= 1'b0;
      hr2         <= 1'b0;
      d1          <= '0;
      state       <= IDLE;
      phase       <= 1'b0;
      hi          <= '0;
      col         <= '0;
      line        <= '0;
      bcnt        <= '0;
      sof_arm     <= 1'b0;
      lerr_frm    <= 1'b0;
      frame_cnt_o <= '0;
      line_err_o  <= 1'b0;
      frame_err_o <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      vs1 <= cam_vsync_i;
      vs2 <= vs1;
      hr1 <= cam_href_i;
      hr2 <= hr1;
      d1  <= cam_data_i;

      line_err_o  <= lerr_set | (line_err_o & ~clr_err_i);
      frame_err_o <= ferr_set | (frame_err_o & ~clr_err_i);
      ovf_o       <= ovf_set | (ovf_o & ~clr_err_i);

      if (!en_i) begin
        state    <= IDLE;
        phase    <= 1'b0;
        col      <= '0;
        line     <= '0;
        bcnt     <= '0;
        sof_arm  <= 1'b0;
        lerr_frm <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= WAIT_VS;
          WAIT_VS: begin
            if (vs_rise) begin
              state   <= WAIT_LINE;
              phase   <= 1'b0;
              col     <= '0;
              line    <= '0;
              bcnt    <= '0;
              sof_arm <= 1'b1;
            end
          end
          WAIT_LINE, LINE: begin
            if (vs_rise) begin
              if ((line == LN_END) & ~lerr_frm & ~hr1)
                frame_cnt_o <= frame_cnt_o + 16'd1;
              state    <= WAIT_LINE;
              phase    <= 1'b0;
              col      <= '0;
              line     <= '0;
              bcnt     <= '0;
              sof_arm  <= 1'b1;
              lerr_frm <= 1'b0;
            end else if (state == WAIT_LINE) begin
              if (hr_rise) state <= LINE;
            end else if (hr_fall) begin
              state <= WAIT_LINE;
              phase <= 1'b0;
              col   <= '0;
              bcnt  <= '0;
              if (line != LN_END) line <= line + LW'(1);
              if (lerr_set) lerr_frm <= 1'b1;
            end
          end
        endcase

        if (byte_ok) begin
          phase <= ~phase;
          if (bcnt != B_MAX) bcnt <= bcnt + BW'(1);
          if (!phase) begin
            hi <= d1;
          end else begin
            if (col != COL_END) col <= col + CW'(1);
            if (push_req) sof_arm <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (!en_i) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wr] <= {sof_arm, eol, eof, hi, d1};
        wr      <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      if (push & ~pop) cnt <= cnt + (AW + 1)'(1);
      else if (pop & ~push) cnt <= cnt - (AW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_cam_rx_if.sv
// Scoreboard bench for cam_rx_if with a tiny 4x2 frame and a 2-entry FIFO.
module tb_cam_rx_if;

  localparam int HRES  = 4;
  localparam int VRES  = 2;
  localparam int DEPTH = 2;

  logic        clk, rst_n, en;
  logic        vsync, href;
  logic [7:0]  data;
  logic [15:0] pix_data;
  logic        pix_sof, pix_eol, pix_eof, pix_valid, pix_ready;
  logic [15:0] frame_cnt;
  logic        line_err, frame_err, ovf, clr_err;

  cam_rx_if #(.HRES(HRES), .VRES(VRES), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .cam_vsync_i (vsync),
    .cam_href_i  (href),
    .cam_data_i  (data),
    .pix_data_o  (pix_data),
    .pix_sof_o   (pix_sof),
    .pix_eol_o   (pix_eol),
    .pix_eof_o   (pix_eof),
    .pix_valid_o (pix_valid),
    .pix_ready_i (pix_ready),
    .frame_cnt_o (frame_cnt),
    .line_err_o  (line_err),
    .frame_err_o (frame_err),
    .ovf_o       (ovf),
    .clr_err_i   (clr_err)
  );

  int n_chk;
  int n_fail;
  logic [18:0] q[$];
  int bidx;
  int m_line;
  bit m_sof;
  bit model_on;
  logic [HRES-1:0] keep;
  int rmode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bval(input int k);
    return 8'(8'h12 + 8'h22 * k);
  endfunction

  // ready driver
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'b0;
        default: pix_ready = ~pix_ready;
      endcase
    end
  end

  // scoreboard pop side
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && en && pix_valid && pix_ready) begin
        e = (q.size() != 0) ? {13'b0, q.pop_front()} : 32'hFFFF_FFFF;
        check("pix", {13'b0, pix_sof, pix_eol, pix_eof, pix_data}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic vsync_pulse();
    vsync = 1'b1;
    m_sof = 1'b1;
    m_line = 0;
    bidx = 0;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_line(input int nbytes, input int en_at);
    logic [7:0] hb;
    logic [7:0] b;
    int col;
    hb = 8'h0;
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      if (i == en_at) en = 1'b1;
      b = bval(bidx);
      bidx++;
      data = b;
      if (i % 2 == 0) begin
        hb = b;
      end else begin
        col = i / 2;
        if (col < HRES) begin
          if (model_on && keep[col])
            q.push_back({m_sof, col == HRES - 1,
                         (col == HRES - 1) && (m_line == VRES - 1), hb, b});
          m_sof = 1'b0;
        end
      end
      tick();
    end
    href = 1'b0;
    data = 8'h0;
    repeat (3) tick();
    if (m_line < VRES) m_line++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    repeat (2) tick();
    check(tag, q.size(), 0);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rmode = 0;
    keep = '1;
    model_on = 1'b0;
    m_sof = 1'b0;
    m_line = 0;
    bidx = 0;
    rst_n = 1'b0;
    en = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    data = 8'h0;
    clr_err = 1'b0;
    repeat (3) tick();
    check("rst_valid", pix_valid, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_flags", {line_err, frame_err, ovf}, 0);
    check("rst_data", pix_data, 0);
    rst_n = 1'b1;
    tick();

    // nominal frame
    en = 1'b1;
    model_on = 1'b1;
    repeat (3) tick();
    vsync_pulse();
    send_line(8, -1);
    send_line(8, -1);
    drain("nom_drain");
    vsync_pulse();
    check("nom_fcnt", frame_cnt, 1);
    check("nom_flags", {line_err, frame_err, ovf}, 0);

    // backpressure: ready low for one line
    rmode = 1;
    keep = 4'b0011;
    send_line(8, -1);
    check("bp_valid", pix_valid, 1);
    check("bp_hold", pix_data, 16'h1234);
    check("bp_sof", pix_sof, 1);
    check("bp_ovf", ovf, 1);
    rmode = 0;
    keep = '1;
    send_line(8, -1);
    drain("bp_drain");
    clear_errs();
    check("bp_ovf_clr", ovf, 0);

    // 50% ready toggle
    vsync_pulse();
    check("tg_fcnt", frame_cnt, 2);
    rmode = 2;
    send_line(8, -1);
    send_line(8, -1);
    drain("tg_drain");
    rmode = 0;
    check("tg_ovf", ovf, 0);

    // short line
    vsync_pulse();
    check("sh_fcnt0", frame_cnt, 3);
    send_line(7, -1);
    check("sh_lerr", line_err, 1);
    send_line(8, -1);
    drain("sh_drain");
    vsync_pulse();
    check("sh_fcnt", frame_cnt, 3);
    check("sh_ferr", frame_err, 0);
    clear_errs();
    check("sh_lerr_clr", line_err, 0);

    // missing line
    send_line(8, -1);
    drain("ml_drain");
    vsync_pulse();
    check("ml_ferr", frame_err, 1);
    check("ml_fcnt", frame_cnt, 3);
    send_line(8, -1);
    send_line(8, -1);
    drain("ml_drain2");
    vsync_pulse();
    check("ml_fcnt2", frame_cnt, 4);
    clear_errs();
    check("ml_ferr_clr", frame_err, 0);

    // enable mid-frame
    en = 1'b0;
    model_on = 1'b0;
    tick();
    send_line(8, -1);
    send_line(8, 3);
    check("en_quiet", pix_valid, 0);
    check("en_q", q.size(), 0);
    model_on = 1'b1;
    vsync_pulse();
    send_line(8, -1);
    send_line(8, -1);
    drain("en_drain");
    vsync_pulse();
    check("en_fcnt", frame_cnt, 5);
    check("en_flags", {line_err, frame_err, ovf}, 0);

    // reset mid-line with two pixels queued
    model_on = 1'b0;
    rmode = 1;
    repeat (2) tick();
    href = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = bval(i);
      tick();
    end
    check("rl_valid_pre", pix_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    href = 1'b0;
    data = 8'h0;
    check("rl_valid", pix_valid, 0);
    check("rl_fcnt", frame_cnt, 0);
    check("rl_flags", {line_err, frame_err, ovf}, 0);
    check("rl_state", dut.state, 0);
    rmode = 0;
    repeat (4) tick();
    check("rl_empty", pix_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
